// File: rtl/game_pkg.sv
// Shared constants and types for the song playback logic.
package game_pkg;

  localparam int NOTE_BITS    = 7;
  localparam int SONG_BITS    = 2;
  localparam int SONG_STRIDE  = 256;
  localparam int END_MARK_BIT = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREFETCH,
    ST_PLAY
  } seq_state_t;

  function automatic int unsigned song_base(input logic [SONG_BITS-1:0] song);
    return int'(song) * SONG_STRIDE;
  endfunction

endpackage

// File: rtl/song_sequencer_note_timer.sv
// Note-duration down-counter: load starts a slot, tick marks its last cycle.
module note_timer #(
  parameter int NOTE_CYCLES = 50_000_000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear,
  input  logic load,
  output logic tick
);

  localparam int CW = (NOTE_CYCLES > 2) ? $clog2(NOTE_CYCLES) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_in) begin
    if (rst_in || clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(NOTE_CYCLES - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Idles at zero, so tick is only meaningful while a slot is being timed.
  assign tick = (cnt == '0);

endmodule

// File: rtl/song_sequencer.sv
// Plays one song from block memory as a stream of timed notes.
//
//   state       | meaning
//   ST_IDLE     | waiting for start; only state that accepts it
//   ST_PREFETCH | first entry address presented, waiting out memory latency
//   ST_PLAY     | note presented; next entry already being fetched
module song_sequencer
  import game_pkg::*;
#(
  parameter int NOTE_CYCLES  = 50_000_000,
  parameter int BRAM_LATENCY = 2,
  parameter int ADDR_W       = 10
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start,
  input  logic [SONG_BITS-1:0] song_choice,
  input  logic                 abort,
  output logic [ADDR_W-1:0]    bram_addr,
  input  logic [7:0]           bram_data,
  output logic [NOTE_BITS-1:0] note,
  output logic                 note_valid,
  output logic                 note_strobe,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           note_index
);

  localparam int PW = $clog2(BRAM_LATENCY + 2);

  seq_state_t           state;
  logic [SONG_BITS-1:0] song_q;
  logic [7:0]           off_q;
  logic                 last_q;
  logic [PW-1:0]        pf_cnt;
  logic                 tick;
  logic                 fetch_slot;
  logic                 end_slot;
  logic                 timer_load;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [SONG_BITS-1:0] s,
                                                input logic [7:0] o);
    return ADDR_W'(song_base(s) + 32'(o));
  endfunction

  // A slot boundary: either the first word has landed or the current note expired.
  assign fetch_slot = ((state == ST_PREFETCH) && (pf_cnt == '0)) ||
                      ((state == ST_PLAY) && tick);
  assign end_slot   = bram_data[END_MARK_BIT] || last_q;
  assign timer_load = fetch_slot && !abort;

  note_timer #(.NOTE_CYCLES(NOTE_CYCLES)) u_timer (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clear  (abort),
    .load   (timer_load),
    .tick   (tick)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= ST_IDLE;
      bram_addr   <= '0;
      note        <= '0;
      note_index  <= '0;
      note_valid  <= 1'b0;
      note_strobe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      song_q      <= '0;
      off_q       <= '0;
      last_q      <= 1'b0;
      pf_cnt      <= '0;
    end else begin
      note_strobe <= 1'b0;
      done        <= 1'b0;
      if (abort) begin
        state      <= ST_IDLE;
        note       <= '0;
        note_valid <= 1'b0;
        busy       <= 1'b0;
        last_q     <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              song_q    <= song_choice;
              off_q     <= '0;
              last_q    <= 1'b0;
              bram_addr <= addr_of(song_choice, 8'd0);
              pf_cnt    <= PW'(BRAM_LATENCY);
              busy      <= 1'b1;
              state     <= ST_PREFETCH;
            end
          end
          ST_PREFETCH, ST_PLAY: begin
            if (fetch_slot) begin
              if (end_slot) begin
                state      <= ST_IDLE;
                done       <= 1'b1;
                busy       <= 1'b0;
                note_valid <= 1'b0;
                note       <= '0;
                last_q     <= 1'b0;
              end else begin
                note        <= bram_data[NOTE_BITS-1:0];
                note_index  <= off_q;
                note_valid  <= 1'b1;
                note_strobe <= 1'b1;
                state       <= ST_PLAY;
                // Entry 255 is the last one a song owns; never step into the next song.
                if (off_q == 8'hFF) begin
                  last_q <= 1'b1;
                end else begin
                  off_q     <= off_q + 8'd1;
                  bram_addr <= addr_of(song_q, off_q + 8'd1);
                end
              end
            end else if (state == ST_PREFETCH) begin
              pf_cnt <= pf_cnt - PW'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
